// File: rtl/delay_line_scheduler_pkg.sv
// Shared constants for the delay-line scheduler: FSM state encoding,
// default geometry and the per-channel region width helper.
package delay_sched_pkg;

    localparam int unsigned DEF_NUM_CH      = 4;
    localparam int unsigned DEF_SAMPLE_BITS = 12;
    localparam int unsigned DEF_ADDR_BITS   = 8;
    localparam int unsigned RAM_DATA_BITS   = 16;

    localparam int unsigned STATE_BITS = 2;
    localparam logic [STATE_BITS-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_BITS-1:0] ST_WRITE = 2'd1;
    localparam logic [STATE_BITS-1:0] ST_READ  = 2'd2;
    localparam logic [STATE_BITS-1:0] ST_DONE  = 2'd3;

    // Pointer width of one channel's slice of the shared RAM.
    function automatic int unsigned region_bits(input int unsigned addr_bits,
                                                input int unsigned num_ch);
        return addr_bits - $clog2(num_ch);
    endfunction

endpackage

// File: rtl/delay_line_scheduler_if.sv
// RAM port bundle between the scheduler (master) and the shared
// single-port-per-direction RAM (slave). Read data returns one clk after
// the ram_re cycle.
//   ram_waddr/ram_wdata/ram_we : write port
//   ram_raddr/ram_re           : read request
//   ram_rdata                  : registered read data from the RAM
interface delay_line_scheduler_if #(
    parameter int unsigned ADDR_BITS = delay_sched_pkg::DEF_ADDR_BITS
);
    import delay_sched_pkg::*;

    logic [ADDR_BITS-1:0]     ram_waddr;
    logic [RAM_DATA_BITS-1:0] ram_wdata;
    logic                     ram_we;
    logic [ADDR_BITS-1:0]     ram_raddr;
    logic                     ram_re;
    logic [RAM_DATA_BITS-1:0] ram_rdata;

    modport master (
        output ram_waddr, ram_wdata, ram_we, ram_raddr, ram_re,
        input  ram_rdata
    );

    modport slave (
        input  ram_waddr, ram_wdata, ram_we, ram_raddr, ram_re,
        output ram_rdata
    );

endinterface

// File: rtl/delay_line_scheduler.sv
// Time-multiplexes NUM_CH circular delay lines onto one shared RAM. On each
// sample_strobe every channel writes its new sample at {ch, wptr} and reads
// back the sample tap[ch] frames old from {ch, wptr - tap[ch]}.
//   clk, rst_n     : clock, synchronous active-low reset
//   sample_strobe  : one-cycle frame pulse
//   din, tap       : packed per-channel samples / delay lengths (ch0 in LSBs)
//   ram            : RAM bus (master side)
//   tap_out        : packed delayed samples, held between frames
//   out_valid      : one-cycle pulse in the DONE cycle
//   busy, overrun  : frame in progress / sticky strobe-while-busy
module delay_line_scheduler
    import delay_sched_pkg::*;
#(
    parameter int unsigned NUM_CH      = DEF_NUM_CH,
    parameter int unsigned SAMPLE_BITS = DEF_SAMPLE_BITS,
    parameter int unsigned ADDR_BITS   = DEF_ADDR_BITS,
    localparam int unsigned REGION_BITS = region_bits(ADDR_BITS, NUM_CH),
    localparam int unsigned CH_BITS     = $clog2(NUM_CH)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            sample_strobe,
    input  logic [NUM_CH*SAMPLE_BITS-1:0]   din,
    input  logic [NUM_CH*REGION_BITS-1:0]   tap,
    delay_line_scheduler_if.master          ram,
    output logic [NUM_CH*SAMPLE_BITS-1:0]   tap_out,
    output logic                            out_valid,
    output logic                            busy,
    output logic                            overrun
);

    logic [STATE_BITS-1:0]  state, state_nxt;
    logic [CH_BITS-1:0]     ch, ch_nxt;
    logic [REGION_BITS-1:0] wptr, wptr_nxt;
    logic                   latch_c;
    logic [SAMPLE_BITS-1:0] wr_sample_c;
    logic [REGION_BITS-1:0] rd_off_c;

    logic [SAMPLE_BITS-1:0] din_q [NUM_CH];
    logic [REGION_BITS-1:0] tap_q [NUM_CH];
    logic                   cap_pending;
    logic [CH_BITS-1:0]     cap_ch;

    // Only the low SAMPLE_BITS of a RAM word carry the sample.
    logic unused_rdata_hi_c;
    assign unused_rdata_hi_c = ^ram.ram_rdata[RAM_DATA_BITS-1:SAMPLE_BITS];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, channel/pointer sequencing and RAM operand selection.
    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        wptr_nxt  = wptr;
        latch_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sample_strobe) begin
                    state_nxt = ST_WRITE;
                    ch_nxt    = '0;
                    latch_c   = 1'b1;
                end
            end
            ST_WRITE: state_nxt = ST_READ;
            ST_READ: begin
                if (ch == CH_BITS'(NUM_CH - 1)) begin
                    state_nxt = ST_DONE;
                end else begin
                    ch_nxt    = ch + CH_BITS'(1);
                    state_nxt = ST_WRITE;
                end
            end
            ST_DONE: begin
                wptr_nxt  = wptr + REGION_BITS'(1);
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // The first write of a frame is issued on the strobe edge itself,
        // before din_q holds the new frame, so take lane 0 straight from din.
        wr_sample_c = latch_c ? din[SAMPLE_BITS-1:0] : din_q[ch_nxt];
        // Region-width subtraction wraps inside the channel's own slice.
        rd_off_c    = wptr - tap_q[ch_nxt];
    end

    // Registered outputs, holding registers and read-data capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch            <= '0;
            wptr          <= '0;
            ram.ram_we    <= 1'b0;
            ram.ram_waddr <= '0;
            ram.ram_wdata <= '0;
            ram.ram_re    <= 1'b0;
            ram.ram_raddr <= '0;
            out_valid     <= 1'b0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
            cap_pending   <= 1'b0;
            cap_ch        <= '0;
            tap_out       <= '0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                din_q[i] <= '0;
                tap_q[i] <= '0;
            end
        end else begin
            ch   <= ch_nxt;
            wptr <= wptr_nxt;

            if (latch_c) begin
                for (int i = 0; i < int'(NUM_CH); i++) begin
                    din_q[i] <= din[i*SAMPLE_BITS +: SAMPLE_BITS];
                    tap_q[i] <= tap[i*REGION_BITS +: REGION_BITS];
                end
            end

            ram.ram_we    <= (state_nxt == ST_WRITE);
            ram.ram_waddr <= (state_nxt == ST_WRITE) ? {ch_nxt, wptr} : '0;
            ram.ram_wdata <= (state_nxt == ST_WRITE) ?
                             RAM_DATA_BITS'($signed(wr_sample_c)) : '0;
            ram.ram_re    <= (state_nxt == ST_READ);
            ram.ram_raddr <= (state_nxt == ST_READ) ? {ch_nxt, rd_off_c} : '0;

            // out_valid marks the DONE cycle; the last lane's capture lands
            // on the edge that closes it.
            out_valid <= (state_nxt == ST_DONE);
            busy      <= (state_nxt != ST_IDLE);

            if (sample_strobe && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end

            // Read data is on the bus the cycle after ram_re.
            cap_pending <= ram.ram_re;
            cap_ch      <= ch;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (cap_pending && (cap_ch == CH_BITS'(i))) begin
                    tap_out[i*SAMPLE_BITS +: SAMPLE_BITS] <=
                        ram.ram_rdata[SAMPLE_BITS-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_delay_line_scheduler.sv
// Self-checking bench for delay_line_scheduler with a 1-cycle-latency RAM
// model, a tap_out scoreboard and a RAM address-region monitor.
module tb_delay_line_scheduler;
    import delay_sched_pkg::*;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SB     = 12;
    localparam int unsigned AB     = 8;
    localparam int unsigned RB     = 6;
    localparam int unsigned DW     = NUM_CH * SB;
    localparam int unsigned TW     = NUM_CH * RB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sample_strobe;
    logic [DW-1:0] din;
    logic [TW-1:0] tap;
    logic [DW-1:0] tap_out;
    logic          out_valid;
    logic          busy;
    logic          overrun;

    always #5 clk = ~clk;

    delay_line_scheduler_if #(.ADDR_BITS(AB)) ram_bus ();

    delay_line_scheduler #(
        .NUM_CH(NUM_CH), .SAMPLE_BITS(SB), .ADDR_BITS(AB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_strobe(sample_strobe),
        .din(din), .tap(tap), .ram(ram_bus), .tap_out(tap_out),
        .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    // RAM model: write and registered read, both on the rising edge.
    logic [15:0] mem [0:255];
    always @(posedge clk) begin
        if (ram_bus.ram_we) mem[ram_bus.ram_waddr] <= ram_bus.ram_wdata;
        if (ram_bus.ram_re) ram_bus.ram_rdata <= mem[ram_bus.ram_raddr];
    end

    int n_cmp = 0;
    int n_bad = 0;
    int n_valid = 0;

    typedef struct {
        logic [DW-1:0] val;
        logic [DW-1:0] mask;
    } exp_t;
    exp_t sb[$];

    // Scoreboard: tap_out is complete the cycle after out_valid.
    logic ov_seen = 1'b0;
    always @(negedge clk) begin
        if (ov_seen) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected_out_valid: got out_valid with no frame queued");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ((tap_out & e.mask) !== (e.val & e.mask)) begin
                    n_bad++;
                    $display("FAIL sb_tap_out: got %h expected %h (mask %h)",
                             tap_out, e.val, e.mask);
                end
            end
        end
        ov_seen = out_valid;
        if (out_valid) n_valid++;
    end

    // Address monitor: the k-th write of a frame must land in region k and
    // each read must stay in the region just written.
    int w_idx = 0;
    always @(negedge clk) begin
        logic [1:0] er;
        if (!busy) w_idx = 0;
        if (ram_bus.ram_we || ram_bus.ram_re) begin
            n_cmp++;
            if (ram_bus.ram_we && ram_bus.ram_re) begin
                n_bad++;
                $display("FAIL mon_we_re_overlap: got we=1 re=1 expected not both");
            end
        end
        if (ram_bus.ram_we) begin
            er = 2'(w_idx);
            n_cmp++;
            if (ram_bus.ram_waddr[AB-1:RB] !== er) begin
                n_bad++;
                $display("FAIL mon_write_region: got %0d expected %0d",
                         ram_bus.ram_waddr[AB-1:RB], er);
            end
            w_idx++;
        end
        if (ram_bus.ram_re) begin
            er = 2'(w_idx - 1);
            n_cmp++;
            if (ram_bus.ram_raddr[AB-1:RB] !== er) begin
                n_bad++;
                $display("FAIL mon_read_region: got %0d expected %0d",
                         ram_bus.ram_raddr[AB-1:RB], er);
            end
        end
    end

    function automatic logic [DW-1:0] pack4(input int a, input int b,
                                            input int c, input int d);
        logic [DW-1:0] r;
        r = {12'(d), 12'(c), 12'(b), 12'(a)};
        return r;
    endfunction

    function automatic logic [TW-1:0] pack_tap(input int a, input int b,
                                               input int c, input int d);
        logic [TW-1:0] r;
        r = {6'(d), 6'(c), 6'(b), 6'(a)};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the expectation, pulse the strobe; returns in frame cycle 1.
    task automatic start_frame(input logic [DW-1:0] d, input logic [TW-1:0] t,
                               input logic [DW-1:0] ev, input logic [DW-1:0] m);
        exp_t e;
        e.val  = ev;
        e.mask = m;
        sb.push_back(e);
        din = d;
        tap = t;
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
    endtask

    // Full frame; returns in frame cycle 10 (idle, tap_out complete).
    task automatic run_frame(input logic [DW-1:0] d, input logic [TW-1:0] t,
                             input logic [DW-1:0] ev, input logic [DW-1:0] m);
        start_frame(d, t, ev, m);
        repeat (9) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sample_strobe = 1'b0;
        din = '0;
        tap = '0;
        repeat (3) tick();
        n_cmp++;
        if ({busy, out_valid, overrun, ram_bus.ram_we, ram_bus.ram_re} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {busy, out_valid, overrun, ram_bus.ram_we, ram_bus.ram_re});
        end
        n_cmp++;
        if (tap_out !== '0) begin
            n_bad++;
            $display("FAIL reset_tap_out: got %h expected 0", tap_out);
        end
        n_cmp++;
        if ({ram_bus.ram_waddr, ram_bus.ram_raddr, ram_bus.ram_wdata} !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_ram_bus: got %h %h %h expected 0 0 0",
                     ram_bus.ram_waddr, ram_bus.ram_raddr, ram_bus.ram_wdata);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_frame();
        logic [DW-1:0] ev;
        ev = pack4(100, -5, 2047, -2048);
        start_frame(ev, '0, ev, '1);
        for (int c = 1; c <= 9; c++) begin
            n_cmp++;
            if ({busy, out_valid} !== {1'b1, (c == 9)}) begin
                n_bad++;
                $display("FAIL single_busy_valid_c%0d: got %b%b expected 1%b",
                         c, busy, out_valid, (c == 9));
            end
            if (c == 1) begin
                n_cmp++;
                if ({ram_bus.ram_we, ram_bus.ram_waddr, ram_bus.ram_wdata} !== {1'b1, 8'h00, 16'd100}) begin
                    n_bad++;
                    $display("FAIL single_write_ch0: got we=%b a=%h d=%h expected 1 00 0064",
                             ram_bus.ram_we, ram_bus.ram_waddr, ram_bus.ram_wdata);
                end
            end
            if (c == 2) begin
                n_cmp++;
                if ({ram_bus.ram_re, ram_bus.ram_raddr} !== {1'b1, 8'h00}) begin
                    n_bad++;
                    $display("FAIL single_read_ch0: got re=%b a=%h expected 1 00",
                             ram_bus.ram_re, ram_bus.ram_raddr);
                end
            end
            if (c == 3) begin
                n_cmp++;
                if ({ram_bus.ram_waddr, ram_bus.ram_wdata} !== {8'h40, 16'hFFFB}) begin
                    n_bad++;
                    $display("FAIL single_write_ch1_sext: got a=%h d=%h expected 40 fffb",
                             ram_bus.ram_waddr, ram_bus.ram_wdata);
                end
            end
            tick();
        end
        n_cmp++;
        if ({busy, out_valid} !== 2'b00 || tap_out !== ev) begin
            n_bad++;
            $display("FAIL single_result: got busy=%b ov=%b tap_out=%h expected 0 0 %h",
                     busy, out_valid, tap_out, ev);
        end
        // Second frame: write pointer must have advanced to 1.
        start_frame(ev, '0, ev, '1);
        n_cmp++;
        if (ram_bus.ram_waddr !== 8'h01) begin
            n_bad++;
            $display("FAIL single_wptr_advance: got waddr=%h expected 01", ram_bus.ram_waddr);
        end
        repeat (9) tick();
    endtask

    task automatic test_delay_wrap();
        logic [DW-1:0] m;
        for (int k = 0; k < 70; k++) begin
            m = '1;
            if (k < 10) m[2*SB-1:SB] = '0;
            run_frame(pack4(k + 500, k, -k, 7), pack_tap(0, 10, 0, 0),
                      pack4(k + 500, k - 10, -k, 7), m);
        end
    endtask

    task automatic test_max_tap();
        logic [DW-1:0] m;
        for (int k = 1; k <= 64; k++) begin
            m = '1;
            if (k != 64) m[SB-1:0] = '0;
            run_frame(pack4(k, 3 * k, 0, -1), pack_tap(63, 0, 0, 0),
                      pack4(1, 3 * k, 0, -1), m);
        end
    endtask

    task automatic test_overrun();
        logic [DW-1:0] ev;
        int nv;
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_pre: got %b expected 0", overrun);
        end
        ev = pack4(11, 22, 33, 44);
        start_frame(ev, '0, ev, '1);
        repeat (3) tick();
        din = pack4(900, 901, 902, 903);
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        n_cmp++;
        if ({overrun, busy} !== 2'b11) begin
            n_bad++;
            $display("FAIL overrun_set: got overrun=%b busy=%b expected 1 1", overrun, busy);
        end
        repeat (4) tick();
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_valid_c9: got %b expected 1", out_valid);
        end
        tick();
        n_cmp++;
        if (tap_out !== ev) begin
            n_bad++;
            $display("FAIL overrun_result: got %h expected %h", tap_out, ev);
        end
        nv = n_valid;
        repeat (15) tick();
        n_cmp++;
        if (n_valid != nv || overrun !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_no_extra: got extra=%0d overrun=%b busy=%b expected 0 1 0",
                     n_valid - nv, overrun, busy);
        end
    endtask

    task automatic test_mid_reset();
        logic [DW-1:0] ev;
        int nv;
        start_frame(pack4(5, 6, 7, 8), '0, '0, '0);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({busy, out_valid, overrun} !== 3'b000 || tap_out !== '0) begin
            n_bad++;
            $display("FAIL midreset_clear: got busy=%b ov=%b overrun=%b tap_out=%h expected 0 0 0 0",
                     busy, out_valid, overrun, tap_out);
        end
        rst_n = 1'b1;
        sb.delete();
        nv = n_valid;
        repeat (12) tick();
        n_cmp++;
        if (n_valid != nv || tap_out !== '0) begin
            n_bad++;
            $display("FAIL midreset_aborted: got valids=%0d tap_out=%h expected 0 0",
                     n_valid - nv, tap_out);
        end
        ev = pack4(-1, 1, -2047, 5);
        start_frame(ev, '0, ev, '1);
        n_cmp++;
        if (ram_bus.ram_waddr !== 8'h00) begin
            n_bad++;
            $display("FAIL midreset_wptr_restart: got waddr=%h expected 00", ram_bus.ram_waddr);
        end
        tick();
        n_cmp++;
        if (ram_bus.ram_raddr !== 8'h00) begin
            n_bad++;
            $display("FAIL midreset_raddr: got raddr=%h expected 00", ram_bus.ram_raddr);
        end
        repeat (8) tick();
    endtask

    task automatic test_strobe_at_done();
        logic [DW-1:0] ev;
        int nv;
        ev = pack4(300, -300, 1, 0);
        nv = n_valid;
        start_frame(ev, '0, ev, '1);
        repeat (8) tick();
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        n_cmp++;
        if ({overrun, busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL done_strobe: got overrun=%b busy=%b expected 1 0", overrun, busy);
        end
        repeat (12) tick();
        n_cmp++;
        if (n_valid != nv + 1) begin
            n_bad++;
            $display("FAIL done_strobe_valids: got %0d expected 1", n_valid - nv);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        ram_bus.ram_rdata = 16'h0;
        test_reset();
        test_single_frame();
        test_delay_wrap();
        test_max_tap();
        test_overrun();
        test_mid_reset();
        test_strobe_at_done();
        tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d frames outstanding expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/delay_line_scheduler.md
DELAY_LINE_SCHEDULER -- requirements
Module: delay_line_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, the number of delay channels sharing one RAM (power of 2, 2..8).
REQ-002 The block SHALL have parameter SAMPLE_BITS, default 12, the signed sample width.
REQ-003 The block SHALL have parameter ADDR_BITS, default 8, the RAM address width (256 x 16 block).
REQ-004 The block SHALL have derived constant REGION_BITS = ADDR_BITS - log2(NUM_CH), the per-channel region pointer width (default 6, i.e. 64 entries).
REQ-005 The block SHALL have port clk, input, 1 bit, the system clock; one clock only.
REQ-006 The block SHALL have port rst_n, input, 1 bit, the reset: synchronous, active-low.
REQ-007 The block SHALL have port sample_strobe, input, 1 bit, a one-cycle pulse marking a new audio sample frame.
REQ-008 The block SHALL have port din, input, NUM_CH*SAMPLE_BITS bits, the packed signed channel samples (ch0 in the LSBs).
REQ-009 The block SHALL have port tap, input, NUM_CH*REGION_BITS bits, the packed per-channel delay lengths in samples.
REQ-010 The block SHALL have port ram_waddr, output, ADDR_BITS bits, the RAM write address.
REQ-011 The block SHALL have port ram_wdata, output, 16 bits, the RAM write data (sample sign-extended to 16 bits).
REQ-012 The block SHALL have port ram_we, output, 1 bit, the RAM write enable.
REQ-013 The block SHALL have port ram_raddr, output, ADDR_BITS bits, the RAM read address.
REQ-014 The block SHALL have port ram_re, output, 1 bit, the RAM read enable.
REQ-015 The block SHALL have port ram_rdata, input, 16 bits, the RAM read data, valid one clk after the ram_re cycle.
REQ-016 The block SHALL have port tap_out, output, NUM_CH*SAMPLE_BITS bits, the packed delayed samples, held between frames.
REQ-017 The block SHALL have port out_valid, output, 1 bit, a one-cycle pulse when every tap_out lane has been updated.
REQ-018 The block SHALL have port busy, output, 1 bit, high while a frame is in progress.
REQ-019 The block SHALL have port overrun, output, 1 bit, a sticky flag: a strobe arrived while busy.

Function
REQ-020 FSM states SHALL be IDLE, WRITE, READ and DONE, with a channel counter ch in 0..NUM_CH-1.
REQ-021 In IDLE, on sample_strobe, the block SHALL latch din and tap into holding registers, set ch=0, and go to WRITE.
REQ-022 In WRITE, the block SHALL drive ram_we=1, ram_waddr={ch, wptr} and ram_wdata=sext(din[ch]), then go to READ.
REQ-023 In READ, the block SHALL drive ram_re=1 and ram_raddr={ch, (wptr - tap[ch]) mod 2^REGION_BITS}. If ch<NUM_CH-1 it SHALL increment ch and go to WRITE; otherwise it SHALL go to DONE.
REQ-024 In the cycle after each READ, the block SHALL capture ram_rdata[SAMPLE_BITS-1:0] into tap_out[ch_of_that_read].
REQ-025 In DONE, the block SHALL pulse out_valid=1, increment wptr modulo 2^REGION_BITS, and go to IDLE.
REQ-026 Latency SHALL be: strobe in cycle 0, out_valid in cycle 2*NUM_CH+1 (9 for the default), giving busy high for cycles 1..2*NUM_CH+1.
REQ-027 ram_we and ram_re SHALL be 0 outside WRITE and READ respectively, and never both 1 in the same cycle.
REQ-028 tap=0 SHALL return the sample written in the same frame; tap=2^REGION_BITS-1 SHALL return the oldest sample held.
REQ-029 Read address subtraction SHALL wrap within the channel region and never cross into another channel's region.
REQ-030 A strobe while busy SHALL be ignored (no state disturbance) and SHALL set overrun; overrun SHALL be cleared only by reset.
REQ-031 A strobe coincident with DONE SHALL be treated as while-busy.
REQ-032 tap_out lanes SHALL be updated only by their own capture, so they hold stable outside captures.

Reset
REQ-033 With rst_n=0 at a clk edge, the block SHALL go to IDLE and clear ch=0, wptr=0, tap_out=0, out_valid=0, busy=0, overrun=0, ram_we=0 and ram_re=0; the address and wdata outputs SHALL be 0.
REQ-034 Reset mid-frame SHALL abort the frame with no out_valid, and any pending capture SHALL be discarded.
REQ-035 RAM contents SHALL NOT be cleared; stale data after reset is acceptable.

Structure
REQ-036 A shared package delay_sched_pkg SHALL hold the FSM state encoding, the default constants and a function computing REGION_BITS.
REQ-037 No sub-module is required; the RAM SHALL be instantiated by the parent alongside this block.

Verification
REQ-038 The bench SHALL check, with a 1-cycle-latency RAM model: reset, one strobe, din ch0..3 = 100,-5,2047,-2048, taps all 0 -> out_valid at cycle 9 with tap_out = 100,-5,2047,-2048 and wptr=1.
REQ-039 The bench SHALL check: ch1 fed frame index k for 70 frames with tap[1]=10 -> frames from index 10 onward show tap_out[1]=k-10, correct across the 63->0 wrap.
REQ-040 The bench SHALL check: tap[0]=63 with ch0 fed 1..64 -> frame 64 returns 1, and no other region is written (address-range monitor).
REQ-041 The bench SHALL check: a strobe at cycle 4 of a frame -> overrun=1, that frame completes normally, and the second strobe produces no extra out_valid.
REQ-042 The bench SHALL check: rst_n low at cycle 5 of a frame -> next cycle busy=0, tap_out=0, no out_valid; a following strobe completes normally with wptr restarting at 0.
